// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants: RV32I major opcodes, bubble encoding, fetch FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package rv_pipe_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Masking (rather than slicing) keeps every input bit referenced.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / hold / bubble control and decoded field slices.
// One-cycle latency from load to outputs; bubble beats load, neither means hold (stall).
module if_id_reg
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INST = rv_pipe_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [6:0]  opcode,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            inst  <= NOP_INST;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end
    end

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, variable-latency imem handshake, one-entry skid buffer, IF/ID register.
// Ack in cycle N shows on id_* in N+1; load_stall holds IF/ID, redirect flushes and wins.
module if_fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = rv_pipe_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd
);

    fetch_state_t state;
    logic         req_q;
    logic [31:0]  fetch_pc;
    logic [31:0]  target;
    logic [31:0]  hold_inst;
    logic [31:0]  hold_pc;

    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  ifid_pc;
    logic [31:0]  ifid_inst;

    // req_q comes out of reset already set so the first request appears the cycle
    // rst falls; gating with rst keeps the bus quiet for the whole reset window.
    assign imem_req  = req_q & ~rst;
    assign imem_addr = fetch_pc;

    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_pc     = fetch_pc;
        ifid_inst   = imem_rdata;
        unique case (state)
            FETCH: begin
                if (redirect)
                    ifid_bubble = 1'b1;
                else if (!load_stall) begin
                    ifid_load   = imem_ack;
                    ifid_bubble = !imem_ack;
                end
            end
            HOLD: begin
                ifid_pc   = hold_pc;
                ifid_inst = hold_inst;
                if (redirect)
                    ifid_bubble = 1'b1;
                else if (!load_stall)
                    ifid_load = 1'b1;
            end
            DRAIN: ifid_bubble = 1'b1;
            default: ifid_bubble = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            req_q     <= 1'b1;
            fetch_pc  <= RESET_PC;
            target    <= RESET_PC;
            hold_inst <= NOP_INST;
            hold_pc   <= 32'h0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            fetch_pc <= pc_align(redirect_pc);
                        end else begin
                            fetch_pc <= fetch_pc + 32'd4;
                            if (load_stall) begin
                                hold_inst <= imem_rdata;
                                hold_pc   <= fetch_pc;
                                state     <= HOLD;
                                req_q     <= 1'b0;
                            end
                        end
                    end else if (redirect) begin
                        // Request already on the bus must complete at its old address.
                        target <= pc_align(redirect_pc);
                        state  <= DRAIN;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        fetch_pc <= pc_align(redirect_pc);
                        state    <= FETCH;
                        req_q    <= 1'b1;
                    end else if (!load_stall) begin
                        state <= FETCH;
                        req_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        fetch_pc <= redirect ? pc_align(redirect_pc) : target;
                        state    <= FETCH;
                    end else if (redirect) begin
                        target <= pc_align(redirect_pc);
                    end
                end
                default: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (ifid_load),
        .bubble    (ifid_bubble),
        .load_pc   (ifid_pc),
        .load_inst (ifid_inst),
        .valid     (id_valid),
        .pc        (id_pc),
        .inst      (id_inst),
        .opcode    (id_opcode),
        .rs1       (id_rs1),
        .rs2       (id_rs2),
        .rd        (id_rd)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: behavioural fetch model compared every cycle plus literal pins.
module tb_if_fetch_stage;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] WPC  = 32'hFFFF_FFFC;
    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        id_valid;
    logic [31:0] id_pc, id_inst;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    logic        w_ack = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_id_valid;
    logic [31:0] w_id_pc, w_id_inst;
    logic [6:0]  w_id_opcode;
    logic [4:0]  w_id_rs1, w_id_rs2, w_id_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RPC), .NOP_INST(NOPI)) dut (
        .clk(clk), .rst(rst), .load_stall(load_stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_valid(id_valid),
        .id_pc(id_pc), .id_inst(id_inst), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd)
    );

    if_fetch_stage #(.RESET_PC(WPC), .NOP_INST(NOPI)) dut_wrap (
        .clk(clk), .rst(rst), .load_stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .id_valid(w_id_valid),
        .id_pc(w_id_pc), .id_inst(w_id_inst), .id_opcode(w_id_opcode),
        .id_rs1(w_id_rs1), .id_rs2(w_id_rs2), .id_rd(w_id_rd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the fetcher either waits on a parked instruction, flushes a stale
    // request, or streams sequential addresses.
    bit          started = 1'b0;
    bit          m_parked, m_flushing;
    logic [31:0] m_pc, m_target, m_park_pc, m_park_inst;
    logic        m_vld;
    logic [31:0] m_idpc, m_inst;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            m_pc <= RPC; m_parked <= 1'b0; m_flushing <= 1'b0;
            m_vld <= 1'b0; m_idpc <= 32'h0; m_inst <= NOPI;
        end else if (m_parked) begin
            if (redirect) begin
                m_parked <= 1'b0; m_pc <= redirect_pc & 32'hFFFF_FFFC;
                m_vld <= 1'b0; m_idpc <= 32'h0; m_inst <= NOPI;
            end else if (!load_stall) begin
                m_parked <= 1'b0;
                m_vld <= 1'b1; m_idpc <= m_park_pc; m_inst <= m_park_inst;
            end
        end else if (m_flushing) begin
            m_vld <= 1'b0; m_idpc <= 32'h0; m_inst <= NOPI;
            if (imem_ack) begin
                m_flushing <= 1'b0;
                m_pc <= redirect ? (redirect_pc & 32'hFFFF_FFFC) : m_target;
            end else if (redirect) begin
                m_target <= redirect_pc & 32'hFFFF_FFFC;
            end
        end else if (redirect) begin
            m_vld <= 1'b0; m_idpc <= 32'h0; m_inst <= NOPI;
            if (imem_ack) m_pc <= redirect_pc & 32'hFFFF_FFFC;
            else begin m_target <= redirect_pc & 32'hFFFF_FFFC; m_flushing <= 1'b1; end
        end else if (imem_ack) begin
            m_pc <= m_pc + 32'd4;
            if (load_stall) begin
                m_parked <= 1'b1; m_park_pc <= m_pc; m_park_inst <= imem_rdata;
            end else begin
                m_vld <= 1'b1; m_idpc <= m_pc; m_inst <= imem_rdata;
            end
        end else if (!load_stall) begin
            m_vld <= 1'b0; m_idpc <= 32'h0; m_inst <= NOPI;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model imem_req", imem_req, !rst && !m_parked);
            check("model imem_addr", imem_addr, m_pc);
            check("model id_valid", id_valid, m_vld);
            check("model id_pc", id_pc, m_idpc);
            check("model id_inst", id_inst, m_inst);
            check("model id_opcode", id_opcode, m_inst[6:0]);
            check("model id_rs1", id_rs1, m_inst[19:15]);
            check("model id_rs2", id_rs2, m_inst[24:20]);
            check("model id_rd", id_rd, m_inst[11:7]);
        end
    end

    // Applies inputs for one cycle, then leaves time for in-cycle literal checks.
    task automatic drive(input logic r, input logic s, input logic re, input logic [31:0] rp,
                         input logic a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst = r; load_stall = s; redirect = re; redirect_pc = rp;
        imem_ack = a; imem_rdata = d;
        #2;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        check("rst1 imem_req", imem_req, 0);
        check("rst1 id_valid", id_valid, 0);
        check("rst1 id_inst", id_inst, 32'h13);
        drive(1, 0, 0, 0, 0, 0);
        check("rst2 imem_req", imem_req, 0);
        check("rst2 id_opcode", id_opcode, 7'h13);
        check("rst2 id_rd", id_rd, 0);
        drive(0, 0, 0, 0, 1, 32'h0050_0093);
        check("first imem_req", imem_req, 1);
        check("first imem_addr", imem_addr, 32'h100);
        drive(0, 0, 0, 0, 1, 32'h0010_0113);
        check("s0 id_pc", id_pc, 32'h100);
        check("s0 id_rd", id_rd, 1);
        check("s0 id_opcode", id_opcode, 7'h13);
        check("s0 imem_addr", imem_addr, 32'h104);
        drive(0, 1, 0, 0, 1, 32'h0020_8193);
        check("s1 id_pc", id_pc, 32'h104);
        check("s1 id_rd", id_rd, 2);
        check("stall ack addr", imem_addr, 32'h108);
        drive(0, 1, 0, 0, 0, 0);
        check("stall id_pc", id_pc, 32'h104);
        check("stall imem_req", imem_req, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("unstall id_pc", id_pc, 32'h104);
        check("unstall imem_req", imem_req, 0);
        drive(0, 0, 1, 32'h200, 0, 0);
        check("after stall id_pc", id_pc, 32'h108);
        check("after stall id_valid", id_valid, 1);
        check("after stall addr", imem_addr, 32'h10C);
        drive(0, 0, 0, 0, 0, 0);
        check("drain addr 1", imem_addr, 32'h10C);
        check("drain valid 1", id_valid, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("drain addr 2", imem_addr, 32'h10C);
        drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("drain addr 3", imem_addr, 32'h10C);
        check("drain valid 3", id_valid, 0);
        drive(0, 1, 0, 0, 1, 32'h0041_A223);
        check("post drain addr", imem_addr, 32'h200);
        check("stale discarded", id_inst, 32'h13);
        drive(0, 1, 1, 32'h301, 0, 0);
        check("hold req", imem_req, 0);
        check("hold id_valid", id_valid, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("redir hold addr", imem_addr, 32'h300);
        check("redir hold req", imem_req, 1);
        check("redir hold bubble", id_inst, 32'h13);
        drive(0, 0, 0, 0, 1, 32'h00C5_8533);
        drive(0, 0, 0, 0, 0, 0);
        check("add id_pc", id_pc, 32'h300);
        check("add id_rs1", id_rs1, 11);
        check("add id_rs2", id_rs2, 12);
        check("add id_rd", id_rd, 10);
        check("add id_opcode", id_opcode, 7'h33);
        check("add next addr", imem_addr, 32'h304);
        drive(0, 0, 0, 0, 0, 0);
        check("idle bubble", id_valid, 0);
        drive(1, 0, 0, 0, 1, 32'h1234_5678);
        check("midrst req", imem_req, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("postrst addr", imem_addr, 32'h100);
        check("postrst req", imem_req, 1);
        check("postrst valid", id_valid, 0);
        drive(0, 0, 0, 0, 0, 0);
        w_ack = 1'b1; w_rdata = 32'h0000_0537;
        check("wrap req", w_req, 1);
        check("wrap addr", w_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0);
        w_ack = 1'b0;
        check("wrap id_pc", w_id_pc, 32'hFFFF_FFFC);
        check("wrap id_valid", w_id_valid, 1);
        check("wrap id_rd", w_id_rd, 10);
        check("wrap next addr", w_addr, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        check("wrap bubble", w_id_valid, 0);
        for (int i = 0; i < 48; i++) begin
            drive(0, (i % 7 == 3) || (i % 7 == 4), (i % 11 == 5),
                  32'h400 + 32'(i * 8) + 32'(i & 3), (i % 3 != 1),
                  {12'(i), 5'(i + 1), 3'b000, 5'(i), 7'h13});
        end
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
